// File: rtl/fpu_writeback_pkg.sv
// Shared types for the floating-point writeback path: ALU opcodes, exception flags, queue entries.
// Entry rd storage is sized by RD_MAX_W; instantiations must keep RD_W <= RD_MAX_W.
package fpu_writeback_pkg;

  localparam int RD_MAX_W = 8;

  typedef enum logic [3:0] {
    FADD     = 4'd0,
    FSUB     = 4'd1,
    FMUL     = 4'd2,
    FDIV     = 4'd3,
    FSQRT    = 4'd4,
    FMIN     = 4'd5,
    FMAX     = 4'd6,
    FEQ      = 4'd7,
    FLT      = 4'd8,
    FCVT_W_S = 4'd9,
    FCVT_S_W = 4'd10,
    FMV_X_W  = 4'd11,
    BEQZ     = 4'd12,
    JAL      = 4'd13
  } alu_instruction_t;

  // Bit order matches the architectural fflags CSR: {NV,DZ,OF,UF,NX}.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef struct packed {
    logic [31:0]         data;
    logic [RD_MAX_W-1:0] rd;
    logic                is_int;
    fflags_t             flags;
  } wb_entry_t;

endpackage

// File: rtl/fpu_result_classify.sv
// Combinational classification of an ALU result: target register file and IEEE exception flags.
// Flags are produced only for FADD/FSUB/FMUL/FDIV; every other opcode yields zero flags.
module fpu_result_classify
  import fpu_writeback_pkg::*;
(
  input  logic [31:0]      result,
  input  alu_instruction_t instr,
  output logic             is_int,
  output fflags_t          flags
);

  logic [7:0]  exp_f;
  logic [22:0] mant_f;
  logic        exp_max;
  logic        exp_zero;
  logic        mant_zero;
  logic        arith;
  logic        unused_sign;

  assign exp_f       = result[30:23];
  assign mant_f      = result[22:0];
  assign unused_sign = result[31];
  assign exp_max     = (exp_f == 8'hFF);
  assign exp_zero    = (exp_f == 8'h00);
  assign mant_zero   = (mant_f == 23'd0);

  always_comb begin
    flags  = '0;
    is_int = instr inside {FEQ, FCVT_W_S, BEQZ, JAL};
    arith  = instr inside {FADD, FSUB, FMUL, FDIV};
    if (arith) begin
      flags.nv = exp_max && !mant_zero;
      flags.of = exp_max && mant_zero;
      flags.uf = exp_zero && !mant_zero;
      flags.nx = (exp_max && mant_zero) || (exp_zero && !mant_zero);
      flags.dz = (instr == FDIV) && exp_max && mant_zero;
    end
  end

endmodule

// File: rtl/fpu_writeback.sv
// FPU result queue feeding the register-file write port; one cycle accept-to-wb_valid, no bypass.
// in_ready drops when full; sticky fflags accumulate on retire only when FPU_WB_FFLAGS_EN is defined.
module fpu_writeback
  import fpu_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RD_W  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  alu_instruction_t         in_instr,
  input  logic [RD_W-1:0]          in_rd,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [31:0]              wb_data,
  output logic [RD_W-1:0]          wb_rd,
  output logic                     wb_is_int,
  output logic [4:0]               fflags,
  input  logic                     fflags_clr,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_idx, rd_idx;
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [RD_W-1:0]  rdx_q  [DEPTH];
  logic [RD_W-1:0]  rdx_d  [DEPTH];
  logic             int_q  [DEPTH];
  logic             int_d  [DEPTH];
`ifdef FPU_WB_FFLAGS_EN
  fflags_t          flags_q [DEPTH];
  fflags_t          flags_d [DEPTH];
  fflags_t          fflags_q, fflags_d;
`endif

  logic             empty, full, push, pop;
  logic             cls_is_int;
  fflags_t          cls_flags;
  wb_entry_t        head;
  logic [RD_MAX_W-1:0] unused_head_rd;

  fpu_result_classify u_classify (
    .result (in_result),
    .instr  (in_instr),
    .is_int (cls_is_int),
    .flags  (cls_flags)
  );

  assign wr_idx    = wr_ptr_q[PTR_W-1:0];
  assign rd_idx    = rd_ptr_q[PTR_W-1:0];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign in_ready  = !full;
  assign wb_valid  = !empty;
  assign push      = in_valid && !full;
  assign pop       = !empty && wb_ready;
  assign occupancy = wr_ptr_q - rd_ptr_q;

  // Head view is forced to zero while empty so the write port never shows stale data.
  always_comb begin
    head = '0;
    if (!empty) begin
      head.data   = data_q[rd_idx];
      head.rd     = RD_MAX_W'(rdx_q[rd_idx]);
      head.is_int = int_q[rd_idx];
`ifdef FPU_WB_FFLAGS_EN
      head.flags  = flags_q[rd_idx];
`endif
    end
  end

  assign wb_data        = head.data;
  assign wb_rd          = head.rd[RD_W-1:0];
  assign wb_is_int      = head.is_int;
  assign unused_head_rd = head.rd;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    rdx_d    = rdx_q;
    int_d    = int_q;
`ifdef FPU_WB_FFLAGS_EN
    flags_d  = flags_q;
    fflags_d = fflags_q;
    // A clear in the retire cycle leaves exactly the retiring entry's flags.
    if (fflags_clr) fflags_d = '0;
    if (pop)        fflags_d = fflags_t'(fflags_d | head.flags);
    if (push)       flags_d[wr_idx] = cls_flags;
`endif
    if (push) begin
      data_d[wr_idx] = in_result;
      rdx_d[wr_idx]  = in_rd;
      int_d[wr_idx]  = cls_is_int;
      wr_ptr_d       = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        rdx_q[i]   <= '0;
        int_q[i]   <= 1'b0;
`ifdef FPU_WB_FFLAGS_EN
        flags_q[i] <= '0;
`endif
      end
`ifdef FPU_WB_FFLAGS_EN
      fflags_q <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      data_q   <= data_d;
      rdx_q    <= rdx_d;
      int_q    <= int_d;
`ifdef FPU_WB_FFLAGS_EN
      flags_q  <= flags_d;
      fflags_q <= fflags_d;
`endif
    end
  end

`ifdef FPU_WB_FFLAGS_EN
  assign fflags = fflags_q;
`else
  logic [10:0] unused_flags;
  assign fflags       = 5'd0;
  assign unused_flags = {fflags_clr, cls_flags, head.flags};
`endif

endmodule

// File: tb/tb_fpu_writeback.sv
// Bench for fpu_writeback: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a queue-based model of the writeback path.
module tb_fpu_writeback;
  import fpu_writeback_pkg::*;

  localparam int DEPTH = 4;
  localparam int RD_W  = 5;
`ifdef FPU_WB_FFLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_result;
  alu_instruction_t       in_instr;
  logic [RD_W-1:0]        in_rd;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [31:0]            wb_data;
  logic [RD_W-1:0]        wb_rd;
  logic                   wb_is_int;
  logic [4:0]             fflags;
  logic                   fflags_clr;
  logic [$clog2(DEPTH):0] occupancy;

  fpu_writeback #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_instr   (in_instr),
    .in_rd      (in_rd),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .wb_is_int  (wb_is_int),
    .fflags     (fflags),
    .fflags_clr (fflags_clr),
    .occupancy  (occupancy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0]     data;
    logic [RD_W-1:0] rd;
    logic            is_int;
    logic [4:0]      flags;
  } ment_t;

  ment_t      m_q[$];
  logic [4:0] m_fflags = 5'd0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entry contents straight from the IEEE-754 single field rules.
  function automatic ment_t model_entry(input logic [31:0] r, input alu_instruction_t op,
                                        input logic [RD_W-1:0] rd);
    ment_t e;
    int    ex;
    int    mn;
    bit    nv, dz, of, uf;
    ex       = int'(r[30:23]);
    mn       = int'(r[22:0]);
    e.data   = r;
    e.rd     = rd;
    e.is_int = (op == FEQ) || (op == FCVT_W_S) || (op == BEQZ) || (op == JAL);
    e.flags  = 5'd0;
    if (FLAGS_EN && (op == FADD || op == FSUB || op == FMUL || op == FDIV)) begin
      nv = (ex == 255) && (mn != 0);
      of = (ex == 255) && (mn == 0);
      uf = (ex == 0) && (mn != 0);
      dz = (op == FDIV) && of;
      e.flags = {nv, dz, of, uf, of | uf};
    end
    return e;
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_q.delete();
      m_fflags = 5'd0;
    end else begin
      bit    do_pop;
      bit    do_push;
      ment_t e;
      do_pop  = (m_q.size() > 0) && wb_ready;
      do_push = in_valid && (m_q.size() < DEPTH);
      e = model_entry(in_result, in_instr, in_rd);
      if (fflags_clr) m_fflags = 5'd0;
      if (do_pop) begin
        m_fflags = m_fflags | m_q[0].flags;
        void'(m_q.pop_front());
      end
      if (do_push) m_q.push_back(e);
    end
  end

  initial forever begin
    @(negedge clk);
    chk("occupancy", occupancy, m_q.size());
    chk("in_ready", in_ready, m_q.size() < DEPTH);
    chk("wb_valid", wb_valid, m_q.size() != 0);
    chk("fflags", fflags, m_fflags);
    if (m_q.size() != 0) begin
      chk("wb_data", wb_data, m_q[0].data);
      chk("wb_rd", wb_rd, m_q[0].rd);
      chk("wb_is_int", wb_is_int, m_q[0].is_int);
    end else begin
      chk("wb_data_idle", wb_data, 0);
      chk("wb_rd_idle", wb_rd, 0);
      chk("wb_is_int_idle", wb_is_int, 0);
    end
  end

  task automatic retire_one(input alu_instruction_t op, input logic [31:0] r);
    in_valid  = 1'b1;
    in_instr  = op;
    in_result = r;
    in_rd     = 5'd7;
    wb_ready  = 1'b1;
    step();
    in_valid  = 1'b0;
    step();
  endtask

  function automatic logic [31:0] rand_result();
    logic [22:0] mant;
    logic        sgn;
    mant = 23'($urandom);
    sgn  = 1'($urandom);
    case ($urandom_range(0, 3))
      0:       return {sgn, 8'hFF, mant};
      1:       return {sgn, 8'h00, ($urandom_range(0, 3) == 0) ? 23'd0 : mant};
      2:       return {sgn, 8'hFF, 23'd0};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    wb_ready   = 1'b0;
    in_result  = 32'd0;
    in_instr   = FADD;
    in_rd      = '0;
    fflags_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fflags", fflags, 0);
    reset = 1'b0;
    step();

    // Single FADD: visible one cycle after accept, then retired.
    in_valid  = 1'b1;
    in_instr  = FADD;
    in_result = 32'h3F800000;
    in_rd     = 5'd3;
    wb_ready  = 1'b1;
    step();
    in_valid  = 1'b0;
    chk("fadd_valid", wb_valid, 1);
    chk("fadd_data", wb_data, 32'h3F800000);
    chk("fadd_rd", wb_rd, 3);
    chk("fadd_is_int", wb_is_int, 0);
    step();
    chk("fadd_retired", wb_valid, 0);
    chk("fadd_fflags", fflags, 0);

    // Fill to capacity with the write port stalled, then drain in order.
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      in_instr  = FSUB;
      in_result = 32'h100 + 32'(i);
      in_rd     = RD_W'(i);
      step();
    end
    in_result = 32'hDEAD;
    chk("full_occupancy", occupancy, 4);
    chk("full_in_ready", in_ready, 0);
    step();
    chk("full_no_fifth", occupancy, 4);
    in_valid = 1'b0;
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", wb_data, 32'h100 + 32'(i));
      step();
    end
    chk("drain_empty", wb_valid, 0);

    retire_one(FMUL, 32'h7F800000);
    chk("fmul_inf_fflags", fflags, FLAGS_EN ? 5'b00101 : 5'b00000);
    retire_one(FDIV, 32'h7F800000);
    chk("fdiv_inf_fflags", fflags, FLAGS_EN ? 5'b01101 : 5'b00000);

    in_valid  = 1'b1;
    in_instr  = FEQ;
    in_result = 32'd1;
    step();
    in_valid  = 1'b0;
    chk("feq_is_int", wb_is_int, 1);
    chk("feq_data", wb_data, 1);
    step();
    chk("feq_fflags", fflags, FLAGS_EN ? 5'b01101 : 5'b00000);
    in_valid  = 1'b1;
    in_instr  = FCVT_W_S;
    in_result = 32'h7FFFFFFF;
    step();
    in_valid  = 1'b0;
    chk("fcvt_is_int", wb_is_int, 1);
    step();
    chk("fcvt_fflags", fflags, FLAGS_EN ? 5'b01101 : 5'b00000);

    // Clear coinciding with an NV retire keeps only NV.
    wb_ready  = 1'b0;
    in_valid  = 1'b1;
    in_instr  = FADD;
    in_result = 32'h7FC00001;
    step();
    in_valid   = 1'b0;
    wb_ready   = 1'b1;
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    chk("clr_nv_fflags", fflags, FLAGS_EN ? 5'b10000 : 5'b00000);

    // Asynchronous reset with three entries queued.
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_instr  = FMUL;
      in_result = 32'h4000_0000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_occupancy", occupancy, 3);
    reset = 1'b1;
    #1;
    chk("mid_rst_occupancy", occupancy, 0);
    chk("mid_rst_wb_valid", wb_valid, 0);
    chk("mid_rst_fflags", fflags, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    step();
    reset = 1'b0;
    step();

    for (int c = 0; c < 3000; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      wb_ready   = (c % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      fflags_clr = ($urandom_range(0, 15) == 0);
      in_instr   = alu_instruction_t'($urandom_range(0, 13));
      in_result  = rand_result();
      in_rd      = RD_W'($urandom);
      reset      = ($urandom_range(0, 499) == 0);
      step();
    end
    reset      = 1'b0;
    in_valid   = 1'b0;
    fflags_clr = 1'b0;
    wb_ready   = 1'b1;
    repeat (8) step();
    chk("final_empty", wb_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
